// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/writeback, drives the
// datapath mux selects and enables, and handshakes with a variable-latency memory.
module multi_cycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_source,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_RD    = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WR    = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12,
        S_HALT      = 4'd15
    } state_e;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;
    localparam logic [7:0] TIMEOUT_LIM   = 8'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [1:0]       fault_q, fault_d;
    logic             retire;
    logic             funct_ok;
    logic [2:0]       r_alu;
    logic             mem_state;
    logic             timeout;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout   = (wait_cnt_q == TIMEOUT_LIM) && !mem_ready;

    always_comb begin
        funct_ok = 1'b1;
        r_alu    = ALU_AND;
        case (funct)
            6'b100000: r_alu = ALU_ADD;
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b101010: r_alu = ALU_SLT;
            default:   funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        fault_d    = fault_q;
        retire     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_source  = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = 3'b000;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        halted     = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (opcode)
                    OP_R:         state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EXEC;
                    default: begin
                        state_d = S_HALT;
                        fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    state_d = S_HALT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_HALT;
                    fault_d = FAULT_TIMEOUT;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_ctrl  = funct_ok ? r_alu : 3'b000;
                if (funct_ok) begin
                    state_d = S_R_WB;
                end else begin
                    state_d = S_HALT;
                    fault_d = FAULT_ILLEGAL;
                end
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_ctrl  = ALU_SUB;
                pc_source = 2'b01;
                pc_en     = zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_en     = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_HALT;
        endcase

        // Wait counter only runs while parked in a memory state on a stalled access.
        if (mem_state && !mem_ready && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = 8'd0;
        end
        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 8'd0;
            retired_q  <= '0;
            fault_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
            fault_q    <= fault_d;
        end
    end

    assign fault     = fault_q;
    assign retired   = retired_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized bench for multi_cycle_ctrl: each instruction is expanded into its expected
// list of steps, and every cycle's outputs are compared against a per-step output table.
module tb_multi_cycle_ctrl;

    localparam int MEM_TIMEOUT = 15;
    localparam int CNT_W       = 4;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6, S_R_EXEC = 4'd7;
    localparam logic [3:0] S_R_WB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_ADDI_EXEC = 4'd11;
    localparam logic [3:0] S_ADDI_WB = 4'd12, S_HALT = 4'd15;
    localparam int NO_STALL = 99, ANY_MEM = 16;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    logic             clk, rst_n;
    logic [5:0]       opcode, funct;
    logic             zero, mem_ready;
    logic             mem_read, mem_write, i_or_d, ir_write, pc_en;
    logic [1:0]       pc_source, alu_src_b, fault;
    logic             alu_src_a, reg_dst, mem_to_reg, reg_write, halted;
    logic [2:0]       alu_ctrl;
    logic [CNT_W-1:0] retired;
    logic [3:0]       state_dbg;
    logic [16:0]      outs_vec;

    logic [3:0] exp_q[$];
    int         exp_retired, waits, n_vec, n_err;
    logic [1:0] exp_fault, pend_fault;

    multi_cycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_en(pc_en), .pc_source(pc_source), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .halted(halted), .fault(fault), .retired(retired),
        .state_dbg(state_dbg)
    );

    assign outs_vec = {mem_read, mem_write, i_or_d, ir_write, pc_en, pc_source, alu_src_a,
                       alu_src_b, alu_ctrl, reg_dst, mem_to_reg, reg_write, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] r_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic bit funct_legal(input logic [5:0] fn);
        return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
               fn == 6'b100101 || fn == 6'b101010;
    endfunction

    function automatic bit op_legal(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ || op == OP_J || op == OP_ADDI;
    endfunction

    function automatic logic [16:0] exp_outs(input logic [3:0] s, input bit rdy, input bit z,
                                             input logic [5:0] fn);
        bit mr, mw, iod, irw, pce, sa, rd, m2r, rw, hl;
        logic [1:0] ps, sb;
        logic [2:0] ac;
        {mr, mw, iod, irw, pce, sa, rd, m2r, rw, hl} = '0;
        ps = 2'b00; sb = 2'b00; ac = 3'b000;
        case (s)
            S_FETCH:     begin mr = 1; sb = 2'b01; ac = 3'b010; irw = rdy; pce = rdy; end
            S_DECODE:    begin sb = 2'b11; ac = 3'b010; end
            S_MEM_ADDR:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
            S_MEM_RD:    begin mr = 1; iod = 1; end
            S_MEM_WB:    begin rw = 1; m2r = 1; end
            S_MEM_WR:    begin mw = 1; iod = 1; end
            S_R_EXEC:    begin sa = 1; ac = r_alu(fn); end
            S_R_WB:      begin rw = 1; rd = 1; end
            S_BRANCH:    begin sa = 1; ac = 3'b110; ps = 2'b01; pce = z; end
            S_JUMP:      begin ps = 2'b10; pce = 1; end
            S_ADDI_EXEC: begin sa = 1; sb = 2'b10; ac = 3'b010; end
            S_ADDI_WB:   rw = 1;
            S_HALT:      hl = 1;
            default:     ;
        endcase
        return {mr, mw, iod, irw, pce, ps, sa, sb, ac, rd, m2r, rw, hl};
    endfunction

    task automatic reset_model();
        exp_q.delete();
        exp_q.push_back(S_IDLE);
        exp_retired = 0;
        exp_fault   = 2'b00;
        pend_fault  = 2'b00;
        waits       = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(state_dbg), 32'(0));
        check("rst_outs", 32'(outs_vec), 32'(0));
        check("rst_retired", 32'(retired), 32'(0));
        check("rst_fault", 32'(fault), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        reset_model();
    endtask

    task automatic start_instr(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
        exp_q.push_back(S_FETCH);
        exp_q.push_back(S_DECODE);
        pend_fault = 2'b01;
        case (op)
            OP_R: begin
                exp_q.push_back(S_R_EXEC);
                exp_q.push_back(funct_legal(fn) ? S_R_WB : S_HALT);
            end
            OP_LW:   begin exp_q.push_back(S_MEM_ADDR); exp_q.push_back(S_MEM_RD); exp_q.push_back(S_MEM_WB); end
            OP_SW:   begin exp_q.push_back(S_MEM_ADDR); exp_q.push_back(S_MEM_WR); end
            OP_BEQ:  exp_q.push_back(S_BRANCH);
            OP_J:    exp_q.push_back(S_JUMP);
            OP_ADDI: begin exp_q.push_back(S_ADDI_EXEC); exp_q.push_back(S_ADDI_WB); end
            default: exp_q.push_back(S_HALT);
        endcase
    endtask

    // One clock of stimulus, a check of every output, then advance the reference.
    task automatic step_cycle(input bit rdy, input bit z);
        logic [3:0] s;
        bit is_mem;
        s = exp_q[0];
        mem_ready = rdy;
        zero      = z;
        @(negedge clk);
        check("state", 32'(state_dbg), 32'(s));
        check("outs", 32'(outs_vec), 32'(exp_outs(s, rdy, z, funct)));
        check("retired", 32'(retired), 32'(exp_retired));
        check("fault", 32'(fault), 32'(exp_fault));
        @(posedge clk); #1;
        is_mem = (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
        if (s == S_HALT) begin
        end else if (is_mem && !rdy) begin
            if (waits == MEM_TIMEOUT) begin
                exp_q.delete();
                exp_q.push_back(S_HALT);
                exp_fault = 2'b10;
                waits = 0;
            end else begin
                waits++;
            end
        end else begin
            waits = 0;
            void'(exp_q.pop_front());
            if (s == S_MEM_WB || s == S_MEM_WR || s == S_R_WB || s == S_BRANCH ||
                s == S_JUMP || s == S_ADDI_WB)
                exp_retired = (exp_retired + 1) % (1 << CNT_W);
            if (exp_q.size() > 0 && exp_q[0] == S_HALT) exp_fault = pend_fault;
        end
    endtask

    // stall_st selects which state(s) hold mem_ready low for stall_n cycles; zmode 0/1 fixed, 2 random.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int pct,
                             input int stall_st, input int stall_n, input int zmode);
        bit rdy, z, stall_here, is_mem;
        start_instr(op, fn);
        while (exp_q.size() > 0 && exp_q[0] != S_HALT) begin
            is_mem = (exp_q[0] == S_FETCH) || (exp_q[0] == S_MEM_RD) || (exp_q[0] == S_MEM_WR);
            stall_here = (stall_st == ANY_MEM) ? is_mem : (int'(exp_q[0]) == stall_st);
            if (stall_here && waits < stall_n) rdy = 1'b0;
            else rdy = ($urandom_range(99) < pct);
            z = (zmode == 2) ? 1'($urandom_range(1)) : (zmode == 1);
            step_cycle(rdy, z);
        end
    endtask

    task automatic run_halt(input int n);
        for (int i = 0; i < n; i++) step_cycle(1'($urandom_range(1)), 1'($urandom_range(1)));
    endtask

    initial begin
        logic [5:0] op, fn;
        int pick;
        n_vec = 0;
        n_err = 0;
        do_reset();

        run_instr(OP_R, 6'b100000, 100, NO_STALL, 0, 0);
        check("add_retired", 32'(retired), 32'(1));
        run_instr(OP_LW, 6'd0, 100, ANY_MEM, 3, 0);
        run_instr(OP_BEQ, 6'd0, 100, NO_STALL, 0, 1);
        run_instr(OP_BEQ, 6'd0, 100, NO_STALL, 0, 0);
        run_instr(OP_SW, 6'd0, 100, ANY_MEM, 2, 0);
        run_instr(OP_ADDI, 6'd0, 100, NO_STALL, 0, 0);
        run_instr(OP_J, 6'd0, 100, NO_STALL, 0, 0);
        check("mix_retired", 32'(retired), 32'(7));

        run_instr(6'b111111, 6'd0, 100, NO_STALL, 0, 0);
        run_halt(20);
        do_reset();
        run_instr(OP_R, 6'b000001, 100, NO_STALL, 0, 0);
        run_halt(20);
        do_reset();

        run_instr(OP_SW, 6'd0, 100, S_MEM_WR, 1000, 0);
        run_halt(5);
        check("timeout_fault", 32'(fault), 32'(2));
        do_reset();
        run_instr(OP_LW, 6'd0, 100, S_FETCH, 1000, 0);
        run_halt(3);
        do_reset();

        start_instr(OP_SW, 6'd0);
        while (exp_q[0] != S_MEM_WR) step_cycle(1'b1, 1'b0);
        repeat (5) step_cycle(1'b0, 1'b0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_state", 32'(state_dbg), 32'(0));
        check("async_rst_outs", 32'(outs_vec), 32'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        reset_model();

        for (int i = 0; i < 17; i++) run_instr(OP_J, 6'd0, 100, NO_STALL, 0, 0);
        check("wrap_retired", 32'(retired), 32'(1));

        for (int i = 0; i < 300; i++) begin
            pick = $urandom_range(99);
            fn = 6'b100000;
            if (pick < 30) begin
                op = OP_R;
                case ($urandom_range(4))
                    0: fn = 6'b100000;
                    1: fn = 6'b100010;
                    2: fn = 6'b100100;
                    3: fn = 6'b100101;
                    default: fn = 6'b101010;
                endcase
            end else if (pick < 45) op = OP_LW;
            else if (pick < 60) op = OP_SW;
            else if (pick < 75) op = OP_BEQ;
            else if (pick < 85) op = OP_J;
            else if (pick < 96) op = OP_ADDI;
            else if (pick < 98) begin
                op = OP_R;
                do fn = 6'($urandom_range(63)); while (funct_legal(fn));
            end else begin
                do op = 6'($urandom_range(63)); while (op_legal(op));
            end
            run_instr(op, fn, 70, NO_STALL, 0, 2);
            if (exp_q.size() > 0 && exp_q[0] == S_HALT) begin
                run_halt(3);
                do_reset();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
